bk_sub_pipe: RTL and testbench

BK_SUB_PIPE -- requirements
Module: bk_sub_pipe

---
 rtl/bk_pkg.sv | 24 ++
 rtl/bk_gp_node.sv | 24 ++
 rtl/bk_sub_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_bk_sub_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// ----------------------------------------------------------------------------
// bk_pkg -- shared types and constants for the Brent-Kung subtractor pipeline.
//
// Contents:
//   BK_WIDTH  default operand width
//   gp_t      generate/propagate pair carried through the prefix tree
//   s1_bit_t  per-bit payload held in pipeline stage S1
//             (group g/p after the up-sweep plus the bit's half-sum)
// ----------------------------------------------------------------------------
package bk_pkg;

    localparam int BK_WIDTH = 12;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef struct packed {
        gp_t  gp;   // group pair after the up-sweep levels
        logic hs;   // half-sum a ^ ~b, XORed with the carry in S2
    } s1_bit_t;

endpackage

// File: rtl/bk_gp_node.sv
// ----------------------------------------------------------------------------
// bk_gp_node -- one parallel-prefix combine node.
//
//   g_o = gh_i | (ph_i & gl_i)
//   p_o = ph_i & pl_i
//
// Ports:
//   gh_i, ph_i  generate/propagate of the more significant (high) group
//   gl_i, pl_i  generate/propagate of the less significant (low) group
//   g_o,  p_o   combined group generate/propagate
// ----------------------------------------------------------------------------
module bk_gp_node (
    input  logic gh_i,
    input  logic ph_i,
    input  logic gl_i,
    input  logic pl_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gh_i | (ph_i & gl_i);
    assign p_o = ph_i & pl_i;

endmodule

// File: rtl/bk_sub_pipe.sv
// ----------------------------------------------------------------------------
// bk_sub_pipe -- two-stage pipelined subtractor, diff = a - b - bin, built as
// a + ~b + ~bin on a Brent-Kung parallel-prefix carry tree.
//
//   S1 registers the group g/p pairs after the up-sweep (reduction) levels.
//   S2 registers diff/bout (and ovf) after the down-sweep and the sum XOR.
//   Valid/ready handshake on both sides; 2-cycle latency, 1 beat per cycle.
//
// Parameters:
//   WIDTH      operand width in bits (>= 2, any value, not only powers of 2)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts an operand beat (combinational)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result beat valid
//   out_ready  downstream accepts a result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       borrow-out, 1 when a < b + bin (unsigned)
//   ovf        signed overflow, present only when BK_SUB_OVF_EN is defined
// ----------------------------------------------------------------------------
module bk_sub_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BK_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LVLS = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // Bit-level generate/propagate of a + ~b, carry-in = ~bin
    // ------------------------------------------------------------------
    logic cin;
    gp_t  [WIDTH-1:0] base;

    assign cin = ~bin;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            base[i].g = a[i] & ~b[i];
            base[i].p = a[i] ^ ~b[i];
        end
    end

    // ------------------------------------------------------------------
    // Up-sweep. Row 0 folds the carry-in into bit 0, so every later group
    // generate G[i:0] is directly the carry out of bit i. Row l combines
    // nodes whose index+1 is a multiple of 2^l with the node 2^(l-1) below.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= LVLS; l++) begin : g_up
        gp_t [WIDTH-1:0] row;
        if (l == 0) begin : g_base
            for (genvar i = 0; i < WIDTH; i++) begin : g_col
                if (i == 0) begin : g_cin
                    bk_gp_node u_node (
                        .gh_i (base[0].g),
                        .ph_i (base[0].p),
                        .gl_i (cin),
                        .pl_i (1'b0),
                        .g_o  (row[0].g),
                        .p_o  (row[0].p)
                    );
                end else begin : g_pass
                    assign row[i] = base[i];
                end
            end
        end else begin : g_lvl
            localparam int SPAN = 1 << (l - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_col
                if (((i + 1) % (2 * SPAN)) == 0) begin : g_node
                    bk_gp_node u_node (
                        .gh_i (g_up[l-1].row[i].g),
                        .ph_i (g_up[l-1].row[i].p),
                        .gl_i (g_up[l-1].row[i-SPAN].g),
                        .pl_i (g_up[l-1].row[i-SPAN].p),
                        .g_o  (row[i].g),
                        .p_o  (row[i].p)
                    );
                end else begin : g_pass
                    assign row[i] = g_up[l-1].row[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_adv;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_adv;

    // ------------------------------------------------------------------
    // Stage S1 registers
    // ------------------------------------------------------------------
    s1_bit_t [WIDTH-1:0] s1_d;
    s1_bit_t [WIDTH-1:0] s1_q;
    logic                s1_cin_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            s1_d[i].gp = g_up[LVLS].row[i];
            s1_d[i].hs = base[i].p;
        end
    end

    // ------------------------------------------------------------------
    // Down-sweep. Row k uses span 2^(LVLS-1-k) and fills in the nodes that
    // sit halfway between the prefixes the up-sweep already completed.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LVLS; k++) begin : g_dn
        gp_t [WIDTH-1:0] row;
        if (k == 0) begin : g_base
            for (genvar i = 0; i < WIDTH; i++) begin : g_col
                assign row[i] = s1_q[i].gp;
            end
        end else begin : g_lvl
            localparam int SPAN = 1 << (LVLS - 1 - k);
            for (genvar i = 0; i < WIDTH; i++) begin : g_col
                if ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN)) begin : g_node
                    bk_gp_node u_node (
                        .gh_i (g_dn[k-1].row[i].g),
                        .ph_i (g_dn[k-1].row[i].p),
                        .gl_i (g_dn[k-1].row[i-SPAN].g),
                        .pl_i (g_dn[k-1].row[i-SPAN].p),
                        .g_o  (row[i].g),
                        .p_o  (row[i].p)
                    );
                end else begin : g_pass
                    assign row[i] = g_dn[k-1].row[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum XOR and flags. carry[i] is the carry into bit i; the last row's
    // group propagates are not needed once the carries are known.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] fin_p;
    logic [WIDTH-1:0] hs;
    logic [WIDTH-1:0] carry;
    logic             cout;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             unused_p;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            fin_g[i] = g_dn[LVLS-1].row[i].g;
            fin_p[i] = g_dn[LVLS-1].row[i].p;
            hs[i]    = s1_q[i].hs;
        end
    end

    assign unused_p = ^fin_p;
    assign carry    = {fin_g[WIDTH-2:0], s1_cin_q};
    assign cout     = fin_g[WIDTH-1];
    assign diff_d   = hs ^ carry;
    assign bout_d   = ~cout;

`ifdef BK_SUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_d;
    logic ovf_q;
    assign ovf_d = carry[WIDTH-1] ^ cout;
    assign ovf   = ovf_q;
`endif

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset along with the valid
            // bits so that diff/bout read 0, not X, until the first result.
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_cin_q   <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
`ifdef BK_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            // Data loads only on a real beat; idle operands leave S1 alone.
            if (in_ready && in_valid) begin
                s1_q     <= s1_d;
                s1_cin_q <= cin;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
`ifdef BK_SUB_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_bk_sub_pipe.sv
// ----------------------------------------------------------------------------
// tb_bk_sub_pipe -- self-checking bench for bk_sub_pipe (WIDTH = 12).
// Directed steps followed by random traffic; every accepted beat is queued
// with its expected a - b - bin result and compared when it leaves.
// ----------------------------------------------------------------------------
module tb_bk_sub_pipe;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    always #5 clk = ~clk;

    bk_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    exp_t         q[$];
    int           n_pass = 0;
    int           n_chk  = 0;
    int           n_in   = 0;
    int           n_out  = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_diff  = '0;
    logic         held_bout  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the unsigned operand values.
    function automatic exp_t model(input int ai, input int bi, input int ci);
        exp_t e;
        int   r;
        r = ai - bi - ci;
        if (r < 0) r += (1 << W);
        e.d  = r[W-1:0];
        e.bo = (ai < bi + ci);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        in_valid = v;
        a        = av;
        b        = bv;
        bin      = ci;
    endtask

    // One clock: sample handshakes at the falling edge, then return 1 time
    // unit after the rising edge so the caller can look at new outputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_diff",  32'(diff), 32'(held_diff));
            check("stall_bout",  32'(bout), 32'(held_bout));
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 0);
            end else begin
                e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(int'(a), int'(b), int'(bin)));
            n_in++;
        end
        stall_prev = out_valid && !out_ready;
        held_diff  = diff;
        held_bout  = bout;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] sa [4] = '{12'h123, 12'h010, 12'hABC, 12'h7FF};
    logic [W-1:0] sb [4] = '{12'h045, 12'h020, 12'hABC, 12'h800};
    logic         sc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n_in0;
        int n_out0;
        int idx;

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_diff",      32'(diff), 0);
        check("rst_bout",      32'(bout), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  32'(in_ready), 1);

        // ---------------- 5 - 3, latency 2 ----------------
        out_ready = 1'b1;
        drive(1'b1, 12'h005, 12'h003, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("lat1_valid", 32'(out_valid), 0);
        tick();
        check("lat2_valid", 32'(out_valid), 1);
        check("lat2_diff",  32'(diff), 'h002);
        check("lat2_bout",  32'(bout), 0);
        tick();
        check("lat3_valid", 32'(out_valid), 0);

        // ---------------- wrap-around ----------------
        drive(1'b1, 12'h000, 12'h001, 1'b0);
        tick();
        drive(1'b1, 12'hFFF, 12'hFFF, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("wrap0_valid", 32'(out_valid), 1);
        check("wrap0_diff",  32'(diff), 'hFFF);
        check("wrap0_bout",  32'(bout), 1);
        tick();
        check("wrap1_valid", 32'(out_valid), 1);
        check("wrap1_diff",  32'(diff), 'hFFF);
        check("wrap1_bout",  32'(bout), 1);
        tick();
        tick();

        // ---------------- full throughput ----------------
        n_out0 = n_out;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            tick();
            check("tput_in_ready", 32'(in_ready), 1);
            if (i >= 1) check("tput_out_valid", 32'(out_valid), 1);
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        check("tput_count", n_out - n_out0, 10);

        // ---------------- stall with 4 beats offered ----------------
        out_ready = 1'b0;
        n_in0     = n_in;
        for (int c = 0; c < 6; c++) begin
            idx = n_in - n_in0;
            drive(1'b1, sa[idx], sb[idx], sc[idx]);
            tick();
        end
        check("stall_accepted", n_in - n_in0, 2);
        check("stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            idx = n_in - n_in0;
            if (idx >= 4 && q.size() == 0) break;
            if (idx < 4) drive(1'b1, sa[idx], sb[idx], sc[idx]);
            else         drive(1'b0, '0, '0, 1'b0);
            tick();
        end
        check("stall_all_in",  n_in - n_in0, 4);
        check("stall_drained", q.size(), 0);

        // ---------------- reset with 2 beats in flight ----------------
        out_ready = 1'b0;
        drive(1'b1, 12'h111, 12'h011, 1'b0);
        tick();
        drive(1'b1, 12'h222, 12'h022, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("flight_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_diff",  32'(diff), 0);
        n_in -= q.size();
        q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_valid", 32'(out_valid), 0);
        end
        drive(1'b1, 12'h800, 12'h001, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        check("post_rst_beat_valid", 32'(out_valid), 1);
        check("post_rst_beat_diff",  32'(diff), 'h7FF);
        check("post_rst_beat_bout",  32'(bout), 0);
        tick();

        // ---------------- random traffic ----------------
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("rand_lost",   q.size(), 0);
        check("beats_match", n_out, n_in);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
